// File: rtl/alu_operation_sequencer.sv
// Issue/writeback controller driving a register file and a combinational ALU.
// Each accepted operation fetches its operands, executes, then writes back and retires.
module alu_operation_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int FUNC_WIDTH     = 4,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      _clock,
    input  logic                      _reset,
    input  logic                      _instrValid,
    output logic                      instrReady,
    input  logic [FUNC_WIDTH-1:0]     _instrFunc,
    input  logic [REG_ADDR_WIDTH-1:0] _instrDest,
    input  logic [REG_ADDR_WIDTH-1:0] _instrSrcA,
    input  logic [REG_ADDR_WIDTH-1:0] _instrSrcB,
    input  logic                      _instrImmSel,
    input  logic [DATA_WIDTH-1:0]     _instrImm,
    output logic [REG_ADDR_WIDTH-1:0] regReadAddr,
    input  logic [DATA_WIDTH-1:0]     _regReadData,
    output logic                      regWriteEn,
    output logic [REG_ADDR_WIDTH-1:0] regWriteAddr,
    output logic [DATA_WIDTH-1:0]     regWriteData,
    output logic [DATA_WIDTH-1:0]     aluValA,
    output logic [DATA_WIDTH-1:0]     aluValB,
    output logic [FUNC_WIDTH-1:0]     aluFuncCode,
    input  logic [DATA_WIDTH-1:0]     _aluResult,
    input  logic                      _aluOverflow,
    input  logic                      _aluCompareBit,
    output logic                      overflowFlag,
    output logic                      compareFlag,
    output logic                      done,
    output logic [15:0]               retiredCount
);

    localparam logic [FUNC_WIDTH-1:0] FUNC_ADD = FUNC_WIDTH'(0);
    localparam logic [FUNC_WIDTH-1:0] FUNC_SUB = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] FUNC_NOT = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] FUNC_SET = FUNC_WIDTH'(6);
    localparam logic [FUNC_WIDTH-1:0] FUNC_ABS = FUNC_WIDTH'(7);
    localparam logic [FUNC_WIDTH-1:0] FUNC_LSS = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] FUNC_EQL = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] FUNC_GRT = FUNC_WIDTH'(10);

    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, EXECUTE, WRITEBACK} state_t;

    function automatic logic is_single(input logic [FUNC_WIDTH-1:0] f);
        return (f == FUNC_SET) || (f == FUNC_NOT) || (f == FUNC_ABS);
    endfunction

    function automatic logic is_compare(input logic [FUNC_WIDTH-1:0] f);
        return (f == FUNC_LSS) || (f == FUNC_EQL) || (f == FUNC_GRT);
    endfunction

    function automatic logic is_addsub(input logic [FUNC_WIDTH-1:0] f);
        return (f == FUNC_ADD) || (f == FUNC_SUB);
    endfunction

    state_t                    state;
    logic [FUNC_WIDTH-1:0]     func_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q;
    logic [REG_ADDR_WIDTH-1:0] src_b_q;
    logic                      imm_sel_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [DATA_WIDTH-1:0]     op_a;
    logic                      ovf_q;
    logic                      cmp_q;
    logic                      write_pending;

    // A reset landing on the writeback cycle must suppress the strobe in that same cycle.
    assign regWriteEn = write_pending & ~_reset;

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state         <= IDLE;
            instrReady    <= 1'b1;
            regReadAddr   <= '0;
            write_pending <= 1'b0;
            regWriteAddr  <= '0;
            regWriteData  <= '0;
            aluValA       <= '0;
            aluValB       <= '0;
            aluFuncCode   <= '0;
            overflowFlag  <= 1'b0;
            compareFlag   <= 1'b0;
            done          <= 1'b0;
            retiredCount  <= '0;
        end else begin
            done          <= 1'b0;
            write_pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (_instrValid) begin
                        func_q      <= _instrFunc;
                        dest_q      <= _instrDest;
                        src_b_q     <= _instrSrcB;
                        imm_sel_q   <= _instrImmSel;
                        imm_q       <= _instrImm;
                        regReadAddr <= _instrSrcA;
                        instrReady  <= 1'b0;
                        state       <= FETCH_A;
                    end
                end
                FETCH_A: begin
                    op_a <= _regReadData;
                    if (is_single(func_q) || imm_sel_q) begin
                        // Skipping the second read: ALU operands load straight from here.
                        aluValA     <= _regReadData;
                        aluValB     <= is_single(func_q) ? '0 : imm_q;
                        aluFuncCode <= func_q;
                        regReadAddr <= '0;
                        state       <= EXECUTE;
                    end else begin
                        regReadAddr <= src_b_q;
                        state       <= FETCH_B;
                    end
                end
                FETCH_B: begin
                    aluValA     <= op_a;
                    aluValB     <= _regReadData;
                    aluFuncCode <= func_q;
                    regReadAddr <= '0;
                    state       <= EXECUTE;
                end
                EXECUTE: begin
                    ovf_q <= _aluOverflow;
                    cmp_q <= _aluCompareBit;
                    if (!is_compare(func_q)) begin
                        regWriteAddr  <= dest_q;
                        regWriteData  <= _aluResult;
                        write_pending <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= WRITEBACK;
                end
                WRITEBACK: begin
                    retiredCount <= retiredCount + 16'd1;
                    if (is_compare(func_q))
                        compareFlag <= cmp_q;
                    else
                        overflowFlag <= is_addsub(func_q) ? ovf_q : 1'b0;
                    instrReady <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    instrReady <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operation_sequencer.sv
// Directed bench: plays register file and ALU, and predicts every output from an
// operation-level model that counts down each operation's remaining cycles.
module tb_alu_operation_sequencer;

    localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_AND = 4'd2, F_OR = 4'd3, F_XOR = 4'd4;
    localparam logic [3:0] F_NOT = 4'd5, F_SET = 4'd6, F_ABS = 4'd7;
    localparam logic [3:0] F_LSS = 4'd8, F_EQL = 4'd9, F_GRT = 4'd10, F_UND = 4'd15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic [3:0] i_func = '0, i_dest = '0, i_sa = '0, i_sb = '0;
    logic i_imm_sel = 1'b0;
    logic [15:0] i_imm = '0;

    logic instrReady, regWriteEn, overflowFlag, compareFlag, done;
    logic [3:0] regReadAddr, regWriteAddr, aluFuncCode;
    logic [15:0] regReadData, regWriteData, aluValA, aluValB, retiredCount;
    logic [15:0] alu_res;
    logic alu_ovf, alu_cmp;

    logic [15:0] regs [16];
    logic [15:0] mregs [16];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dones = 0;

    always #5 clk = ~clk;

    alu_operation_sequencer dut (
        ._clock(clk), ._reset(rst), ._instrValid(valid), .instrReady(instrReady),
        ._instrFunc(i_func), ._instrDest(i_dest), ._instrSrcA(i_sa), ._instrSrcB(i_sb),
        ._instrImmSel(i_imm_sel), ._instrImm(i_imm),
        .regReadAddr(regReadAddr), ._regReadData(regReadData),
        .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
        .aluValA(aluValA), .aluValB(aluValB), .aluFuncCode(aluFuncCode),
        ._aluResult(alu_res), ._aluOverflow(alu_ovf), ._aluCompareBit(alu_cmp),
        .overflowFlag(overflowFlag), .compareFlag(compareFlag), .done(done),
        .retiredCount(retiredCount)
    );

    // Behavioural ALU: {overflow, compare, result}. Undefined codes give xnor and a stray overflow.
    function automatic logic [17:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic o, c;
        r = '0; o = 1'b0; c = 1'b0;
        case (f)
            F_ADD: begin r = a + b; o = (a[15] == b[15]) && (r[15] != a[15]); end
            F_SUB: begin r = a - b; o = (a[15] != b[15]) && (r[15] != a[15]); end
            F_AND: r = a & b;
            F_OR:  r = a | b;
            F_XOR: r = a ^ b;
            F_NOT: r = ~a;
            F_SET: r = a;
            F_ABS: r = a[15] ? -a : a;
            F_LSS: c = $signed(a) < $signed(b);
            F_EQL: c = (a == b);
            F_GRT: c = $signed(a) > $signed(b);
            default: begin r = ~(a ^ b); o = 1'b1; end
        endcase
        return {o, c, r};
    endfunction

    assign regReadData = regs[regReadAddr];
    assign {alu_ovf, alu_cmp, alu_res} = alu_fn(aluFuncCode, aluValA, aluValB);

    always @(posedge clk) if (regWriteEn) regs[regWriteAddr] <= regWriteData;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operation-level model: rem counts cycles left until the operation has retired.
    int rem = 0;
    int e_lat = 0;
    logic [3:0] e_f, e_dest, e_sa, e_sb;
    logic [15:0] e_a, e_b, e_r;
    logic e_o, e_c, e_cmpop, e_addsub;
    logic m_ovf = 1'b0, m_cmp = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [3:0] exp_ra;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rem = 0; m_ovf = 1'b0; m_cmp = 1'b0; m_cnt = '0;
        end else if (rem != 0) begin
            if (rem == 1) begin
                m_cnt = m_cnt + 16'd1;
                if (e_cmpop) m_cmp = e_c;
                else begin
                    m_ovf = e_addsub ? e_o : 1'b0;
                    mregs[e_dest] = e_r;
                end
            end
            rem--;
        end else if (valid) begin
            logic single;
            e_f = i_func; e_dest = i_dest; e_sa = i_sa; e_sb = i_sb;
            single = (i_func == F_NOT) || (i_func == F_SET) || (i_func == F_ABS);
            e_cmpop = (i_func == F_LSS) || (i_func == F_EQL) || (i_func == F_GRT);
            e_addsub = (i_func == F_ADD) || (i_func == F_SUB);
            e_a = mregs[i_sa];
            e_b = single ? 16'h0 : (i_imm_sel ? i_imm : mregs[i_sb]);
            {e_o, e_c, e_r} = alu_fn(i_func, e_a, e_b);
            e_lat = (single || i_imm_sel) ? 3 : 4;
            rem = e_lat;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (done) dones++;
            exp_ra = '0;
            if (rem != 0 && rem == e_lat) exp_ra = e_sa;
            else if (e_lat == 4 && rem == 3) exp_ra = e_sb;
            chk("instr_ready", 16'(instrReady), 16'(rem == 0));
            chk("done", 16'(done), 16'(rem == 1));
            chk("reg_write_en", 16'(regWriteEn), 16'(rem == 1 && !e_cmpop && !rst));
            if (rem == 1 && !e_cmpop && !rst) begin
                chk("reg_write_addr", 16'(regWriteAddr), 16'(e_dest));
                chk("reg_write_data", regWriteData, e_r);
            end
            chk("reg_read_addr", 16'(regReadAddr), 16'(exp_ra));
            if (rem == 2 || rem == 1) begin
                chk("alu_val_a", aluValA, e_a);
                chk("alu_val_b", aluValB, e_b);
                chk("alu_func", 16'(aluFuncCode), 16'(e_f));
            end
            chk("overflow_flag", 16'(overflowFlag), 16'(m_ovf));
            chk("compare_flag", 16'(compareFlag), 16'(m_cmp));
            chk("retired_count", retiredCount, m_cnt);
        end
    end

    task automatic issue(input logic [3:0] f, input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                         input logic is, input logic [15:0] im, input bit hold, output int acc);
        int n;
        i_func = f; i_dest = d; i_sa = a; i_sb = b; i_imm_sel = is; i_imm = im; valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (instrReady) break;
            n++;
            if (n > 20) begin chk("accept_timeout", 16'd0, 16'd1); break; end
        end
        @(posedge clk); #1;
        acc = cyc;
        if (!hold) valid = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (done) break;
            if (k > 20) begin chk("done_timeout", 16'd0, 16'd1); break; end
        end
    endtask

    task automatic run(input logic [3:0] f, input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                       input logic is, input logic [15:0] im, input int lat);
        int acc, k;
        issue(f, d, a, b, is, im, 1'b0, acc);
        wait_done(k);
        chk("latency", 16'(k), 16'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int acc1, acc2, k, d0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
        regs[1] = 16'h0003; regs[2] = 16'h0004; regs[4] = 16'hFFFF;
        regs[5] = 16'h0001; regs[6] = 16'h8000; regs[7] = 16'h7FFF;
        for (int i = 0; i < 16; i++) mregs[i] = regs[i];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 16'(instrReady), 16'd1);
        chk("reset_count", retiredCount, 16'h0000);
        @(posedge clk); #1;

        run(F_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0, 4);
        chk("add_r3", regs[3], 16'h0007);
        chk("add_ovf", 16'(overflowFlag), 16'd0);
        chk("add_count", retiredCount, 16'd1);

        run(F_SUB, 4'd12, 4'd6, 4'd0, 1'b1, 16'h0001, 3);
        chk("sub_r12", regs[12], 16'h7FFF);
        chk("sub_ovf", 16'(overflowFlag), 16'd1);

        run(F_AND, 4'd8, 4'd1, 4'd2, 1'b0, 16'h0, 4);
        chk("and_r8", regs[8], 16'h0000);
        chk("and_ovf_clear", 16'(overflowFlag), 16'd0);

        run(F_ADD, 4'd13, 4'd7, 4'd0, 1'b1, 16'h0001, 3);
        chk("addi_r13", regs[13], 16'h8000);
        chk("addi_ovf", 16'(overflowFlag), 16'd1);

        run(F_LSS, 4'd0, 4'd4, 4'd5, 1'b0, 16'h0, 4);
        chk("lss_cmp", 16'(compareFlag), 16'd1);
        chk("lss_ovf_kept", 16'(overflowFlag), 16'd1);
        chk("lss_no_write", regs[0], 16'h1000);

        run(F_UND, 4'd10, 4'd1, 4'd2, 1'b0, 16'h0, 4);
        chk("undef_r10", regs[10], 16'hFFF8);
        chk("undef_ovf", 16'(overflowFlag), 16'd0);

        run(F_NOT, 4'd9, 4'd1, 4'd2, 1'b0, 16'h0, 3);
        chk("not_r9", regs[9], 16'hFFFC);

        run(F_ADD, 4'd1, 4'd1, 4'd1, 1'b0, 16'h0, 4);
        chk("self_r1", regs[1], 16'h0006);

        d0 = dones;
        issue(F_EQL, 4'd0, 4'd2, 4'd2, 1'b0, 16'h0, 1'b1, acc1);
        issue(F_GRT, 4'd0, 4'd2, 4'd1, 1'b0, 16'h0, 1'b0, acc2);
        wait_done(k);
        @(posedge clk); #1;
        chk("b2b_gap", 16'(acc2 - acc1), 16'd5);
        chk("b2b_dones", 16'(dones - d0), 16'd2);
        chk("b2b_count", retiredCount, 16'd10);
        chk("b2b_cmp", 16'(compareFlag), 16'd0);

        run(F_ABS, 4'd14, 4'd4, 4'd0, 1'b0, 16'h0, 3);
        chk("abs_r14", regs[14], 16'h0001);

        issue(F_ADD, 4'd11, 4'd1, 4'd2, 1'b0, 16'h0, 1'b0, acc1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("wbrst_no_write", regs[11], 16'h100B);
        chk("wbrst_ready", 16'(instrReady), 16'd1);
        chk("wbrst_ovf", 16'(overflowFlag), 16'd0);
        chk("wbrst_count", retiredCount, 16'd0);
        @(posedge clk); #1;

        rst = 1'b1; valid = 1'b1; i_func = F_ADD; i_dest = 4'd11; i_sa = 4'd1; i_sb = 4'd2; i_imm_sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("rst_valid_ignored", 16'(instrReady), 16'd1);
        @(posedge clk); #1;

        force dut.retiredCount = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.retiredCount;
        run(F_SET, 4'd15, 4'd2, 4'd0, 1'b0, 16'h0, 3);
        chk("set_r15", regs[15], 16'h0004);
        chk("count_wrap", retiredCount, 16'h0000);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
